// File: rtl/csi2_pkt_scheduler_pkg.sv
// Shared types for the CSI-2 packet scheduler: queued event codes,
// CSI-2 short-packet data types and the scheduler FSM states.
package csi2_pkt_scheduler_pkg;

  typedef enum logic [1:0] {
    EV_FS   = 2'd0,
    EV_FE   = 2'd1,
    EV_LONG = 2'd2
  } evt_e;

  localparam logic [5:0] DT_FS = 6'h00;
  localparam logic [5:0] DT_FE = 6'h01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HS_ENTER,
    ST_SEND,
    ST_WAIT_DONE,
    ST_HS_EXIT
  } state_e;

endpackage

// File: rtl/csi2_pkt_scheduler_if.sv
// Lane-controller / packet-formatter handshake bundle.
// master = scheduler side, slave = lane controller + formatter side.
interface csi2_pkt_scheduler_if;
  logic        hs_req;
  logic        hs_rdy;
  logic        pkt_start;
  logic        pkt_long;
  logic [5:0]  pkt_dt;
  logic [1:0]  pkt_vc;
  logic [15:0] pkt_wc;
  logic        pkt_done;

  modport master (
    output hs_req, pkt_start, pkt_long, pkt_dt, pkt_vc, pkt_wc,
    input  hs_rdy, pkt_done
  );

  modport slave (
    input  hs_req, pkt_start, pkt_long, pkt_dt, pkt_vc, pkt_wc,
    output hs_rdy, pkt_done
  );
endinterface

// File: rtl/csi2_pkt_scheduler_evt_fifo.sv
// Small synchronous FIFO for scheduler events. A push while full is
// accepted only when a pop happens in the same cycle.
module csi2_pkt_scheduler_evt_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Pointer/occupancy update and storage write
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/csi2_pkt_scheduler.sv
// CSI-2 packet scheduler: converts FV/LV edges into FS/LONG/FE events,
// queues them and sequences HS entry, packet start, completion, HS exit
// and a minimum LP gap for each one.
module csi2_pkt_scheduler
  import csi2_pkt_scheduler_pkg::*;
#(
  parameter logic [1:0]  VC        = 2'd0,
  parameter logic [5:0]  DT        = 6'h1E,
  parameter logic [15:0] WC        = 16'h01E0,
  parameter logic [15:0] FRAME_MAX = 16'd0,
  parameter int unsigned LP_GAP    = 8,
  parameter int unsigned QDEPTH    = 4
) (
  input  logic                   PIXCLK,
  input  logic                   reset,
  input  logic                   FV,
  input  logic                   LV,
  csi2_pkt_scheduler_if.master   bus,
  output logic                   busy,
  output logic                   q_overflow,
  output logic                   seq_err
);
  localparam logic [15:0] FRAME_INIT = (FRAME_MAX == 16'd0) ? 16'd0 : 16'd1;

  logic        fv_q, lv_q;
  logic        fv_rise, fv_fall, lv_rise, lv_long;
  logic        pend_vld, pend_vld_nxt;
  evt_e        pend_ev, pend_ev_nxt;
  logic        push, pop;
  evt_e        push_ev, head;
  logic [1:0]  fifo_dout;
  logic        fifo_full, fifo_empty;
  state_e      state, state_nxt;
  logic [15:0] gap_cnt;
  logic [15:0] frame_num;
  logic        long_q;
  logic [5:0]  dt_q;
  logic [1:0]  vc_q;
  logic [15:0] wc_q;

  assign fv_rise = FV && !fv_q;
  assign fv_fall = !FV && fv_q;
  assign lv_rise = LV && !lv_q;
  assign lv_long = lv_rise && FV;
  assign head    = evt_e'(fifo_dout);

  // Event arbitration: one push per cycle. A held event goes first; a frame
  // edge colliding with it (FE right after a pending LONG) takes its place.
  always_comb begin
    push         = 1'b0;
    push_ev      = EV_FS;
    pend_vld_nxt = 1'b0;
    pend_ev_nxt  = pend_ev;
    if (pend_vld) begin
      push    = 1'b1;
      push_ev = pend_ev;
      if (fv_rise || fv_fall) begin
        pend_vld_nxt = 1'b1;
        pend_ev_nxt  = fv_rise ? EV_FS : EV_FE;
      end
    end else if (fv_rise || fv_fall) begin
      push    = 1'b1;
      push_ev = fv_rise ? EV_FS : EV_FE;
      if (lv_long) begin
        pend_vld_nxt = 1'b1;
        pend_ev_nxt  = EV_LONG;
      end
    end else if (lv_long) begin
      push    = 1'b1;
      push_ev = EV_LONG;
    end
  end

  csi2_pkt_scheduler_evt_fifo #(.WIDTH(2), .DEPTH(QDEPTH)) u_fifo (
    .clk   (PIXCLK),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_ev),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state and handshake outputs
  always_comb begin
    state_nxt     = state;
    pop           = 1'b0;
    bus.hs_req    = 1'b0;
    bus.pkt_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && gap_cnt == '0) begin
          pop       = 1'b1;
          state_nxt = ST_HS_ENTER;
        end
      end
      ST_HS_ENTER: begin
        bus.hs_req = 1'b1;
        if (bus.hs_rdy) state_nxt = ST_SEND;
      end
      ST_SEND: begin
        bus.hs_req    = 1'b1;
        bus.pkt_start = 1'b1;
        state_nxt     = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        bus.hs_req = 1'b1;
        if (bus.pkt_done) state_nxt = ST_HS_EXIT;
      end
      ST_HS_EXIT: begin
        if (!bus.hs_rdy) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, edge detectors, pending reg, gap/frame counters, packet regs, flags
  always_ff @(posedge PIXCLK) begin
    if (reset) begin
      state      <= ST_IDLE;
      fv_q       <= 1'b0;
      lv_q       <= 1'b0;
      pend_vld   <= 1'b0;
      pend_ev    <= EV_FS;
      gap_cnt    <= '0;
      frame_num  <= FRAME_INIT;
      long_q     <= 1'b0;
      dt_q       <= '0;
      vc_q       <= '0;
      wc_q       <= '0;
      q_overflow <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      state    <= state_nxt;
      fv_q     <= FV;
      lv_q     <= LV;
      pend_vld <= pend_vld_nxt;
      pend_ev  <= pend_ev_nxt;

      if (state == ST_HS_EXIT && !bus.hs_rdy) gap_cnt <= 16'(LP_GAP);
      else if (state == ST_IDLE && gap_cnt != '0) gap_cnt <= gap_cnt - 16'd1;

      if (pop) begin
        long_q <= (head == EV_LONG);
        vc_q   <= VC;
        case (head)
          EV_FS:   begin dt_q <= DT_FS; wc_q <= frame_num; end
          EV_FE:   begin dt_q <= DT_FE; wc_q <= frame_num; end
          default: begin dt_q <= DT;    wc_q <= WC;        end
        endcase
        if (head == EV_FE && FRAME_MAX != 16'd0)
          frame_num <= (frame_num >= FRAME_MAX) ? 16'd1 : frame_num + 16'd1;
      end

      if (push && fifo_full && !pop) q_overflow <= 1'b1;
      if ((lv_rise && !FV) || (bus.pkt_done && state != ST_WAIT_DONE)) seq_err <= 1'b1;
    end
  end

  assign bus.pkt_long = long_q;
  assign bus.pkt_dt   = dt_q;
  assign bus.pkt_vc   = vc_q;
  assign bus.pkt_wc   = wc_q;
  assign busy         = (state != ST_IDLE) || !fifo_empty;
endmodule

// File: tb/tb_csi2_pkt_scheduler.sv
// Self-checking bench for csi2_pkt_scheduler: lane controller echoes hs_req
// after 3 cycles, formatter answers pkt_start with pkt_done ~10 cycles later.
// Expected packets come from a frame-level model fed by the stimulus.
module tb_csi2_pkt_scheduler;
  import csi2_pkt_scheduler_pkg::*;

  localparam logic [1:0]  VC        = 2'd2;
  localparam logic [5:0]  DT        = 6'h1E;
  localparam logic [15:0] WC        = 16'h01E0;
  localparam logic [15:0] FRAME_MAX = 16'd3;
  localparam int          LP_GAP    = 8;
  localparam int          QDEPTH    = 4;

  typedef struct {
    logic [5:0]  dt;
    logic [15:0] wc;
    logic        lng;
  } pkt_t;

  logic PIXCLK = 1'b0;
  logic reset, FV, LV;
  logic busy, q_overflow, seq_err;
  logic hold_rdy;
  logic [2:0] rdy_sr;
  int   done_cnt;

  int   checks = 0;
  int   failures = 0;
  int   start_cnt = 0;
  int   model_fn = 1;
  pkt_t exp_q[$];
  pkt_t cur;
  logic [15:0] short_wc[$];

  csi2_pkt_scheduler_if bus();

  csi2_pkt_scheduler #(
    .VC(VC), .DT(DT), .WC(WC), .FRAME_MAX(FRAME_MAX),
    .LP_GAP(LP_GAP), .QDEPTH(QDEPTH)
  ) u_dut (
    .PIXCLK     (PIXCLK),
    .reset      (reset),
    .FV         (FV),
    .LV         (LV),
    .bus        (bus),
    .busy       (busy),
    .q_overflow (q_overflow),
    .seq_err    (seq_err)
  );

  always #5 PIXCLK = ~PIXCLK;

  // Lane controller: HS state follows hs_req three cycles later
  always @(posedge PIXCLK)
    if (reset) rdy_sr <= '0;
    else       rdy_sr <= {rdy_sr[1:0], bus.hs_req};
  assign bus.hs_rdy = rdy_sr[2] & ~hold_rdy;

  // Formatter: completion pulse ten cycles after start
  always @(posedge PIXCLK)
    if (reset)              done_cnt <= 0;
    else if (bus.pkt_start) done_cnt <= 10;
    else if (done_cnt > 0)  done_cnt <= done_cnt - 1;
  assign bus.pkt_done = (done_cnt == 1);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packet monitor: every start must match the next modelled packet, and
  // the descriptor must still match when the formatter completes.
  always @(negedge PIXCLK) begin
    if (bus.pkt_start) begin
      start_cnt++;
      check("pkt_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        check("pkt_dt", 32'(bus.pkt_dt), 32'(cur.dt));
        check("pkt_wc", 32'(bus.pkt_wc), 32'(cur.wc));
        check("pkt_long", 32'(bus.pkt_long), 32'(cur.lng));
        check("pkt_vc", 32'(bus.pkt_vc), 32'(VC));
        if (!bus.pkt_long) short_wc.push_back(bus.pkt_wc);
      end
    end
    if (bus.pkt_done && bus.hs_req) begin
      check("stable_dt", 32'(bus.pkt_dt), 32'(cur.dt));
      check("stable_wc", 32'(bus.pkt_wc), 32'(cur.wc));
    end
  end

  // LP gap monitor: cycles with hs_rdy and hs_req both low before next request
  int low_cnt = 0;
  bit armed = 1'b0;
  bit req_prev = 1'b0;
  always @(negedge PIXCLK) begin
    if (reset) begin
      armed   = 1'b0;
      low_cnt = 0;
    end else begin
      if (bus.hs_req && !req_prev && armed) begin
        check("lp_gap", 32'(low_cnt >= LP_GAP), 32'd1);
        armed = 1'b0;
      end
      if (bus.hs_rdy) begin
        armed   = 1'b1;
        low_cnt = 0;
      end else if (!bus.hs_req) begin
        low_cnt++;
      end
    end
    req_prev = bus.hs_req;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge PIXCLK);
    #1;
  endtask

  task automatic model_push(input evt_e ev);
    pkt_t p;
    case (ev)
      EV_FS: p = '{dt: DT_FS, wc: 16'(model_fn), lng: 1'b0};
      EV_FE: p = '{dt: DT_FE, wc: 16'(model_fn), lng: 1'b0};
      default: p = '{dt: DT, wc: WC, lng: 1'b1};
    endcase
    exp_q.push_back(p);
    if (ev == EV_FE) model_fn = (model_fn == int'(FRAME_MAX)) ? 1 : model_fn + 1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    FV = 1'b0;
    LV = 1'b0;
    tick(2);
    reset = 1'b0;
    exp_q.delete();
    model_fn = 1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000; i++) begin
      if (!busy && exp_q.size() == 0) break;
      tick(1);
    end
    check("drain", 32'(!busy && exp_q.size() == 0), 32'd1);
    tick(LP_GAP + 6);
  endtask

  task automatic lv_pulse(input int hi);
    LV = 1'b1;
    tick(hi);
    LV = 1'b0;
    tick(1);
  endtask

  task automatic frame(input int nlines);
    FV = 1'b1;
    model_push(EV_FS);
    tick($urandom_range(2, 5));
    for (int l = 0; l < nlines; l++) begin
      model_push(EV_LONG);
      lv_pulse($urandom_range(2, 6));
      tick($urandom_range(1, 4));
    end
    FV = 1'b0;
    model_push(EV_FE);
    tick(2);
    wait_drain();
  endtask

  initial begin
    int s0;
    logic [15:0] wc_seq [8];
    wc_seq = '{16'd1, 16'd1, 16'd2, 16'd2, 16'd3, 16'd3, 16'd1, 16'd1};
    hold_rdy = 1'b0;
    reset = 1'b1;
    FV = 1'b0;
    LV = 1'b0;
    tick(3);
    check("rst_hs_req", 32'(bus.hs_req), 32'd0);
    check("rst_pkt_start", 32'(bus.pkt_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_q_overflow", 32'(q_overflow), 32'd0);
    check("rst_seq_err", 32'(seq_err), 32'd0);
    check("rst_pkt_dt", 32'(bus.pkt_dt), 32'd0);
    check("rst_pkt_wc", 32'(bus.pkt_wc), 32'd0);
    check("rst_pkt_long", 32'(bus.pkt_long), 32'd0);
    check("rst_pkt_vc", 32'(bus.pkt_vc), 32'd0);
    reset = 1'b0;
    tick(2);

    // 1: basic frame with one line -> FS(1), LONG, FE(1)
    s0 = start_cnt;
    frame(1);
    check("t1_starts", 32'(start_cnt - s0), 32'd3);

    // 2: FV and LV rise together -> FS then LONG
    s0 = start_cnt;
    FV = 1'b1;
    LV = 1'b1;
    model_push(EV_FS);
    model_push(EV_LONG);
    tick(4);
    LV = 1'b0;
    tick(3);
    FV = 1'b0;
    model_push(EV_FE);
    tick(2);
    wait_drain();
    check("t2_starts", 32'(start_cnt - s0), 32'd3);
    check("t2_no_overflow", 32'(q_overflow), 32'd0);

    // 4: back-to-back lines stress the LP gap monitor
    frame(3);
    frame(3);
    check("seq_err_clean", 32'(seq_err), 32'd0);

    // 5: frame numbering wraps 3 -> 1
    do_reset();
    tick(2);
    short_wc.delete();
    for (int f = 0; f < 4; f++) frame($urandom_range(1, 3));
    check("t5_short_cnt", 32'(short_wc.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < short_wc.size()) check("t5_frame_wc", 32'(short_wc[i]), 32'(wc_seq[i]));

    // 3: lanes never ready -> one packet in flight, QDEPTH queued, rest dropped
    hold_rdy = 1'b1;
    FV = 1'b1;
    model_push(EV_FS);
    tick(3);
    for (int i = 0; i < 6; i++) begin
      if (i < QDEPTH) model_push(EV_LONG);
      lv_pulse(2);
      tick(1);
    end
    check("t3_overflow", 32'(q_overflow), 32'd1);
    check("t3_busy", 32'(busy), 32'd1);
    check("t3_no_start", 32'(bus.hs_rdy), 32'd0);
    hold_rdy = 1'b0;
    wait_drain();
    FV = 1'b0;
    model_push(EV_FE);
    tick(2);
    wait_drain();
    check("t3_overflow_sticky", 32'(q_overflow), 32'd1);

    // 6: reset during WAIT_DONE, then LV with FV low
    FV = 1'b1;
    model_push(EV_FS);
    s0 = start_cnt;
    for (int i = 0; i < 200; i++) begin
      if (start_cnt != s0) break;
      tick(1);
    end
    check("t6_started", 32'(start_cnt != s0), 32'd1);
    tick(3);
    reset = 1'b1;
    FV = 1'b0;
    LV = 1'b0;
    tick(1);
    check("t6_hs_req", 32'(bus.hs_req), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    tick(1);
    reset = 1'b0;
    exp_q.delete();
    model_fn = 1;
    check("t6_q_overflow", 32'(q_overflow), 32'd0);
    check("t6_seq_err_clr", 32'(seq_err), 32'd0);
    tick(2);
    s0 = start_cnt;
    lv_pulse(3);
    tick(2);
    check("t6_seq_err", 32'(seq_err), 32'd1);
    tick(60);
    check("t6_no_pkt", 32'(start_cnt - s0), 32'd0);
    check("t6_idle", 32'(busy), 32'd0);

    check("model_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
